// File: rtl/pc_cfr_pkg.sv
// Shared definitions for the CFR cancellation pulse generator.
// Contents: control FSM state enum, drop counter width, and the
// round-half-up / symmetric saturation helper used on the product path.
package pc_cfr_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cpg_state_e;

    // Drops dw-1 fractional bits from a Q2.(2*dw-2) accumulator, rounding
    // half-up, and clamps to +/-(2^(dw-1)-1). A 64-bit carrier keeps the
    // helper width-independent; callers size-cast the result to dw bits.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int dw);
        logic signed [63:0] r;
        logic signed [63:0] lim;
        r   = (acc + (64'sd1 <<< (dw - 2))) >>> (dw - 1);
        lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (r > lim) begin
            r = lim;
        end else if (r < -lim) begin
            r = -lim;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_cfr_cmult.sv
// Pipelined complex multiply of the latched peak by a CPW coefficient,
// followed by round-half-up and symmetric saturation.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_i, phase_i          coefficient present this clock; its channel
//   peak_re_i, peak_im_i      latched peak vector (stable for the pulse)
//   coef_re_i, coef_im_i      CPW coefficient, Q1.(DATA_WIDTH-1)
//   valid_o, phase_o          result valid / channel, MUL_LATENCY clocks later
//   re_o, im_o                rounded, saturated result; zero when not valid
module pc_cfr_cmult
    import pc_cfr_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int MUL_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic                         phase_i,
    input  logic signed [DATA_WIDTH-1:0] peak_re_i,
    input  logic signed [DATA_WIDTH-1:0] peak_im_i,
    input  logic signed [DATA_WIDTH-1:0] coef_re_i,
    input  logic signed [DATA_WIDTH-1:0] coef_im_i,
    output logic                         valid_o,
    output logic                         phase_o,
    output logic signed [DATA_WIDTH-1:0] re_o,
    output logic signed [DATA_WIDTH-1:0] im_o
);

    localparam int MW = 2 * DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH + 1;

    logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0] acc_re_d, acc_im_d;
    logic signed [PW-1:0] acc_re_q, acc_im_q;
    logic                 v0_q, ph0_q;
    logic signed [DATA_WIDTH-1:0] rnd_re, rnd_im;

    assign m_rr = MW'(peak_re_i) * MW'(coef_re_i);
    assign m_ii = MW'(peak_im_i) * MW'(coef_im_i);
    assign m_ri = MW'(peak_re_i) * MW'(coef_im_i);
    assign m_ir = MW'(peak_im_i) * MW'(coef_re_i);

    // One extra bit: (-2^(W-1))^2 + (-2^(W-1))^2 does not fit in 2W bits.
    assign acc_re_d = PW'(m_rr) - PW'(m_ii);
    assign acc_im_d = PW'(m_ri) + PW'(m_ir);

    // Coefficient capture stage: products registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            v0_q     <= 1'b0;
            ph0_q    <= 1'b0;
        end else begin
            acc_re_q <= valid_i ? acc_re_d : '0;
            acc_im_q <= valid_i ? acc_im_d : '0;
            v0_q     <= valid_i;
            ph0_q    <= valid_i & phase_i;
        end
    end

    assign rnd_re = v0_q ? DATA_WIDTH'(round_sat(64'(acc_re_q), DATA_WIDTH)) : '0;
    assign rnd_im = v0_q ? DATA_WIDTH'(round_sat(64'(acc_im_q), DATA_WIDTH)) : '0;

    generate
        if (MUL_LATENCY <= 1) begin : g_direct
            assign valid_o = v0_q;
            assign phase_o = ph0_q;
            assign re_o    = rnd_re;
            assign im_o    = rnd_im;
        end else begin : g_pipe
            localparam int D = MUL_LATENCY - 1;
            logic [D-1:0]                 v_q, p_q;
            logic signed [DATA_WIDTH-1:0] re_q [D];
            logic signed [DATA_WIDTH-1:0] im_q [D];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                    p_q <= '0;
                    for (int k = 0; k < D; k++) begin
                        re_q[k] <= '0;
                        im_q[k] <= '0;
                    end
                end else begin
                    v_q[0]  <= v0_q;
                    p_q[0]  <= ph0_q;
                    re_q[0] <= rnd_re;
                    im_q[0] <= rnd_im;
                    for (int k = 1; k < D; k++) begin
                        v_q[k]  <= v_q[k-1];
                        p_q[k]  <= p_q[k-1];
                        re_q[k] <= re_q[k-1];
                        im_q[k] <= im_q[k-1];
                    end
                end
            end

            assign valid_o = v_q[D-1];
            assign phase_o = p_q[D-1];
            assign re_o    = re_q[D-1];
            assign im_o    = im_q[D-1];
        end
    endgenerate

endmodule

// File: rtl/pc_cfr_cpg.sv
// Cancellation pulse generator: accepts a complex peak on its channel slot,
// reads the CPW table on that slot, and emits peak * CPW as a pulse.
//
// state    | meaning
// ST_IDLE  | waiting for a peak on its own channel slot
// ST_RUN   | issuing CPW reads on the peak's slot, addresses 0..len
// ST_DRAIN | last read issued; waiting MUL_LATENCY+1 clocks for the pipe
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   peak_i_in/peak_q_in            peak correction vector
//   peak_phase_in, peak_valid_in   peak channel and strobe
//   peak_ready                     idle, a peak can be accepted
//   ctrl_pulse_len                 pulse length minus one
//   cpw_addr, cpw_en               CPW read port (data one clock later)
//   cpw_data_i/cpw_data_q          CPW coefficient
//   pulse_i/pulse_q, pulse_valid,  cancellation pulse sample and channel
//   pulse_phase
//   busy, drop_count, phase_err    status
module pc_cfr_cpg
    import pc_cfr_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int CPW_ADDR_WIDTH = 8,
    parameter int MUL_LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  peak_i_in,
    input  logic signed [DATA_WIDTH-1:0]  peak_q_in,
    input  logic                          peak_phase_in,
    input  logic                          peak_valid_in,
    output logic                          peak_ready,
    input  logic [CPW_ADDR_WIDTH-1:0]     ctrl_pulse_len,
    output logic [CPW_ADDR_WIDTH-1:0]     cpw_addr,
    output logic                          cpw_en,
    input  logic signed [DATA_WIDTH-1:0]  cpw_data_i,
    input  logic signed [DATA_WIDTH-1:0]  cpw_data_q,
    output logic signed [DATA_WIDTH-1:0]  pulse_i,
    output logic signed [DATA_WIDTH-1:0]  pulse_q,
    output logic                          pulse_valid,
    output logic                          pulse_phase,
    output logic                          busy,
    output logic [DROP_CNT_W-1:0]         drop_count,
    output logic                          phase_err
);

    localparam int DCW = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);

    cpg_state_e                  state_q, state_d;
    logic                        ph_q;
    logic                        phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0] pk_re_q, pk_re_d, pk_im_q, pk_im_d;
    logic [CPW_ADDR_WIDTH-1:0]   len_q, len_d;
    logic                        cpw_en_q, cpw_en_d;
    logic [CPW_ADDR_WIDTH-1:0]   cpw_addr_q, cpw_addr_d;
    logic                        rdv_q;
    logic [DCW-1:0]              dcnt_q, dcnt_d;
    logic [DROP_CNT_W-1:0]       drop_q, drop_d;
    logic                        perr_q, perr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ph_q       <= 1'b0;
            phase_q    <= 1'b0;
            pk_re_q    <= '0;
            pk_im_q    <= '0;
            len_q      <= '0;
            cpw_en_q   <= 1'b0;
            cpw_addr_q <= '0;
            rdv_q      <= 1'b0;
            dcnt_q     <= '0;
            drop_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ~ph_q;
            phase_q    <= phase_d;
            pk_re_q    <= pk_re_d;
            pk_im_q    <= pk_im_d;
            len_q      <= len_d;
            cpw_en_q   <= cpw_en_d;
            cpw_addr_q <= cpw_addr_d;
            rdv_q      <= cpw_en_q;
            dcnt_q     <= dcnt_d;
            drop_q     <= drop_d;
            perr_q     <= perr_d;
        end
    end

    // Reads are launched from the peak's own slot, so each cpw_en lands on
    // the opposite slot and the finished sample comes back on the peak's slot.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pk_re_d    = pk_re_q;
        pk_im_d    = pk_im_q;
        len_d      = len_q;
        cpw_en_d   = 1'b0;
        cpw_addr_d = cpw_addr_q;
        dcnt_d     = dcnt_q;
        drop_d     = drop_q;
        perr_d     = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (peak_valid_in) begin
                    if (peak_phase_in == ph_q) begin
                        state_d    = ST_RUN;
                        phase_d    = peak_phase_in;
                        pk_re_d    = peak_i_in;
                        pk_im_d    = peak_q_in;
                        len_d      = ctrl_pulse_len;
                        cpw_en_d   = 1'b1;
                        cpw_addr_d = '0;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cpw_en_q && (cpw_addr_q == len_q)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = DCW'(MUL_LATENCY);
                end else if (ph_q == phase_q) begin
                    cpw_en_d   = 1'b1;
                    cpw_addr_d = cpw_addr_q + CPW_ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q - DCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && peak_valid_in && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    pc_cfr_cmult #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_LATENCY(MUL_LATENCY)
    ) u_cmult (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (rdv_q),
        .phase_i  (phase_q),
        .peak_re_i(pk_re_q),
        .peak_im_i(pk_im_q),
        .coef_re_i(cpw_data_i),
        .coef_im_i(cpw_data_q),
        .valid_o  (pulse_valid),
        .phase_o  (pulse_phase),
        .re_o     (pulse_i),
        .im_o     (pulse_q)
    );

    assign peak_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign cpw_en     = cpw_en_q;
    assign cpw_addr   = cpw_addr_q;
    assign drop_count = drop_q;
    assign phase_err  = perr_q;

endmodule

// File: tb/tb_pc_cfr_cpg.sv
module tb_pc_cfr_cpg;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] peak_i_in, peak_q_in;
    logic               peak_phase_in, peak_valid_in;
    logic               peak_ready;
    logic [7:0]         ctrl_pulse_len;
    logic [7:0]         cpw_addr;
    logic               cpw_en;
    logic signed [15:0] cpw_data_i = '0;
    logic signed [15:0] cpw_data_q = '0;
    logic signed [15:0] pulse_i, pulse_q;
    logic               pulse_valid, pulse_phase, busy, phase_err;
    logic [15:0]        drop_count;

    pc_cfr_cpg #(.DATA_WIDTH(16), .CPW_ADDR_WIDTH(8), .MUL_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .peak_i_in(peak_i_in), .peak_q_in(peak_q_in),
        .peak_phase_in(peak_phase_in), .peak_valid_in(peak_valid_in),
        .peak_ready(peak_ready), .ctrl_pulse_len(ctrl_pulse_len),
        .cpw_addr(cpw_addr), .cpw_en(cpw_en),
        .cpw_data_i(cpw_data_i), .cpw_data_q(cpw_data_q),
        .pulse_i(pulse_i), .pulse_q(pulse_q),
        .pulse_valid(pulse_valid), .pulse_phase(pulse_phase),
        .busy(busy), .drop_count(drop_count), .phase_err(phase_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic               ph;
    } exp_t;

    exp_t               sb[$];
    int                 en_q[$];
    int                 pv_log[$];
    logic signed [15:0] mem_i [256];
    logic signed [15:0] mem_q [256];
    int                 cyc = 0;
    logic               tb_ph = 1'b0;
    logic [7:0]         exp_addr = '0;
    int                 n_checks = 0;
    int                 n_pass = 0;

    // CPW memory: one clock read latency
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tb_ph <= rst ? 1'b0 : ~tb_ph;
        if (cpw_en) begin
            cpw_data_i <= mem_i[cpw_addr];
            cpw_data_q <= mem_q[cpw_addr];
        end
    end

    function automatic logic signed [15:0] model_rs(input longint acc);
        real    x;
        longint r;
        x = real'(acc) / 32768.0 + 0.5;
        r = longint'($floor(x));
        if (r > 32767)  r = 32767;
        if (r < -32767) r = -32767;
        return 16'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor();
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cpw_en) begin
                    n_checks++;
                    if (cpw_addr !== exp_addr)
                        $display("FAIL cpw_addr order: got %0d expected %0d", cpw_addr, exp_addr);
                    else
                        n_pass++;
                    en_q.push_back(cyc);
                    exp_addr = (cpw_addr == ctrl_pulse_len) ? 8'd0 : exp_addr + 8'd1;
                end
                if (pulse_valid) begin
                    pv_log.push_back(cyc);
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected pulse_valid: got %0d/%0d expected none", pulse_i, pulse_q);
                    end else begin
                        e = sb.pop_front();
                        if (pulse_i !== e.i || pulse_q !== e.q || pulse_phase !== e.ph)
                            $display("FAIL pulse sample: got %0d/%0d ph %0d expected %0d/%0d ph %0d",
                                     pulse_i, pulse_q, pulse_phase, e.i, e.q, e.ph);
                        else
                            n_pass++;
                    end
                    if (en_q.size() > 0) begin
                        lat = cyc - en_q.pop_front();
                        n_checks++;
                        if (lat != 3)
                            $display("FAIL pulse latency: got %0d expected 3", lat);
                        else
                            n_pass++;
                    end
                end else begin
                    n_checks++;
                    if (pulse_i !== '0 || pulse_q !== '0)
                        $display("FAIL idle pulse zero: got %0d/%0d expected 0/0", pulse_i, pulse_q);
                    else
                        n_pass++;
                end
            end
        end
    endtask

    task automatic send_peak(input int pi, input int pq, input logic ph, input int len);
        int n = 0;
        while (tb_ph !== ph && n < 4) begin
            step();
            n++;
        end
        ctrl_pulse_len = 8'(len);
        peak_i_in      = 16'(pi);
        peak_q_in      = 16'(pq);
        peak_phase_in  = ph;
        peak_valid_in  = 1'b1;
        for (int k = 0; k <= len; k++) begin
            longint ai, aq;
            exp_t   e;
            ai   = longint'(pi) * mem_i[k] - longint'(pq) * mem_q[k];
            aq   = longint'(pi) * mem_q[k] + longint'(pq) * mem_i[k];
            e.i  = model_rs(ai);
            e.q  = model_rs(aq);
            e.ph = ph;
            sb.push_back(e);
        end
        step();
        peak_valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!peak_ready && n < 2000) begin
            step();
            n++;
        end
        n_checks++;
        if (!peak_ready)
            $display("FAIL %s idle timeout: got busy after %0d cycles expected idle", name, n);
        else if (pv_log.size() == 0 || cyc != pv_log[$] + 1)
            $display("FAIL %s ready timing: got cycle %0d expected one after last pulse", name, cyc);
        else
            n_pass++;
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL %s missing samples: got %0d left expected 0", name, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        peak_i_in = '0; peak_q_in = '0; peak_phase_in = 1'b0; peak_valid_in = 1'b0;
        ctrl_pulse_len = '0;
        for (int k = 0; k < 256; k++) begin
            mem_i[k] = '0;
            mem_q[k] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        n_checks++; if (peak_ready !== 1'b1) $display("FAIL reset peak_ready: got %b expected 1", peak_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (cpw_en !== 1'b0 || cpw_addr !== 8'd0) $display("FAIL reset cpw: got %b/%0d expected 0/0", cpw_en, cpw_addr); else n_pass++;
        n_checks++; if (pulse_valid !== 1'b0 || pulse_phase !== 1'b0) $display("FAIL reset pulse flags: got %b/%b expected 0/0", pulse_valid, pulse_phase); else n_pass++;
        n_checks++; if (drop_count !== 16'd0) $display("FAIL reset drop_count: got %0d expected 0", drop_count); else n_pass++;
        n_checks++; if (phase_err !== 1'b0) $display("FAIL reset phase_err: got %b expected 0", phase_err); else n_pass++;
    endtask

    task automatic test_phase_err();
        int n = 0;
        pv_log.delete();
        while (tb_ph !== 1'b0 && n < 4) begin step(); n++; end
        peak_i_in = 16'sd5000; peak_q_in = 16'sd0; peak_phase_in = 1'b1; peak_valid_in = 1'b1;
        step();
        peak_valid_in = 1'b0;
        repeat (10) step();
        n_checks++; if (phase_err !== 1'b1) $display("FAIL phase_err set: got %b expected 1", phase_err); else n_pass++;
        n_checks++; if (drop_count !== 16'd0) $display("FAIL phase_err drop: got %0d expected 0", drop_count); else n_pass++;
        n_checks++; if (peak_ready !== 1'b1 || pv_log.size() != 0) $display("FAIL phase_err no pulse: got ready %b pulses %0d expected 1/0", peak_ready, pv_log.size()); else n_pass++;
    endtask

    task automatic test_basic();
        pv_log.delete();
        for (int k = 0; k < 4; k++) begin mem_i[k] = 16'sd16384; mem_q[k] = 16'sd0; end
        send_peak(8192, 0, 1'b0, 3);
        wait_done("basic");
        n_checks++;
        if (pv_log.size() != 4) $display("FAIL basic count: got %0d expected 4", pv_log.size());
        else n_pass++;
        for (int k = 1; k < pv_log.size(); k++) begin
            n_checks++;
            if (pv_log[k] - pv_log[k-1] != 2)
                $display("FAIL basic spacing: got %0d expected 2", pv_log[k] - pv_log[k-1]);
            else
                n_pass++;
        end
    endtask

    task automatic test_len0();
        pv_log.delete();
        mem_i[0] = 16'sd16384; mem_q[0] = 16'sd8192;
        send_peak(1000, -2000, 1'b1, 0);
        wait_done("len0");
        n_checks++;
        if (pv_log.size() != 1) $display("FAIL len0 count: got %0d expected 1", pv_log.size());
        else n_pass++;
    endtask

    task automatic test_saturation();
        pv_log.delete();
        mem_i[0] = -16'sd32768; mem_q[0] = 16'sd0;
        mem_i[1] = -16'sd32768; mem_q[1] = 16'sd0;
        send_peak(32767, 32767, 1'b1, 1);
        wait_done("sat_neg");
        mem_i[0] = -16'sd32768; mem_q[0] = -16'sd32768;
        mem_i[1] = 16'sd32767;  mem_q[1] = -16'sd32768;
        send_peak(-32768, -32768, 1'b0, 1);
        wait_done("sat_wide");
    endtask

    task automatic test_drop();
        pv_log.delete();
        for (int k = 0; k < 16; k++) begin
            mem_i[k] = 16'(k * 997 - 7000);
            mem_q[k] = 16'(5000 - k * 613);
        end
        send_peak(12000, -7000, 1'b0, 15);
        repeat (4) step();
        peak_i_in = 16'sd30000; peak_q_in = 16'sd30000; peak_phase_in = tb_ph; peak_valid_in = 1'b1;
        step();
        peak_valid_in = 1'b0;
        n_checks++;
        if (drop_count !== 16'd1 || busy !== 1'b1) $display("FAIL drop count: got %0d busy %b expected 1 busy 1", drop_count, busy);
        else n_pass++;
        wait_done("drop");
        n_checks++;
        if (pv_log.size() != 16) $display("FAIL drop first pulse: got %0d samples expected 16", pv_log.size());
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int n = 0;
        pv_log.delete();
        for (int k = 0; k < 8; k++) begin mem_i[k] = 16'(3000 * k); mem_q[k] = 16'(-2000 * k); end
        send_peak(20000, 10000, 1'b1, 7);
        while (!(pulse_valid && pv_log.size() == 2) && n < 100) begin step(); n++; end
        n_checks++;
        if (n >= 100) $display("FAIL abort wait: got no sample 2 expected one");
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (pulse_valid !== 1'b0 || pulse_i !== '0 || pulse_q !== '0) $display("FAIL abort pulse: got %b %0d/%0d expected 0 0/0", pulse_valid, pulse_i, pulse_q); else n_pass++;
        n_checks++; if (peak_ready !== 1'b1 || busy !== 1'b0) $display("FAIL abort ready: got %b busy %b expected 1/0", peak_ready, busy); else n_pass++;
        n_checks++; if (cpw_en !== 1'b0 || cpw_addr !== 8'd0) $display("FAIL abort cpw: got %b/%0d expected 0/0", cpw_en, cpw_addr); else n_pass++;
        n_checks++; if (drop_count !== 16'd0 || phase_err !== 1'b0) $display("FAIL abort status: got %0d/%b expected 0/0", drop_count, phase_err); else n_pass++;
        sb.delete();
        en_q.delete();
        pv_log.delete();
        exp_addr = '0;
        rst = 1'b0;
        repeat (20) step();
        n_checks++;
        if (pv_log.size() != 0) $display("FAIL abort residue: got %0d pulses expected 0", pv_log.size());
        else n_pass++;
    endtask

    task automatic test_full_len();
        pv_log.delete();
        for (int k = 0; k < 256; k++) begin
            mem_i[k] = 16'(k * 128 - 16384);
            mem_q[k] = 16'(16000 - k * 100);
        end
        send_peak(23170, -23170, 1'b1, 255);
        wait_done("full_len");
        n_checks++;
        if (pv_log.size() != 256) $display("FAIL full_len count: got %0d expected 256", pv_log.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        pv_log.delete();
        send_peak(-15000, 9000, 1'b0, 2);
        wait_done("b2b_first");
        send_peak(7000, 7000, tb_ph, 1);
        wait_done("b2b_second");
        n_checks++;
        if (pv_log.size() != 5 || drop_count !== 16'd0)
            $display("FAIL b2b: got %0d samples drop %0d expected 5 drop 0", pv_log.size(), drop_count);
        else
            n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        peak_i_in = '0; peak_q_in = '0; peak_phase_in = 1'b0; peak_valid_in = 1'b0;
        ctrl_pulse_len = '0;
        fork
            monitor();
            begin
                test_reset();
                test_phase_err();
                test_basic();
                test_len0();
                test_saturation();
                test_drop();
                test_reset_abort();
                test_full_len();
                test_back_to_back();
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        join
    end

endmodule
